// File: rtl/polar_pkg.sv
// Shared geometry constants and helpers for the SCAN polar decoder message memories.
// Layer L holds two halves of 2^(L-1) messages each, moved in P-message chunks.
package polar_pkg;
  localparam int unsigned Q     = 6;
  localparam int unsigned P     = 64;
  localparam int unsigned N     = 1024;
  localparam int unsigned LOG2N = 10;
  localparam int unsigned LW    = 5;
  localparam int unsigned CW    = P * Q;

  typedef enum logic {WIdle, WBurst} w_state_e;
  typedef enum logic {RIdle, RBurst} r_state_e;

  // Chunks per half: 1 for layers up to 7, then 2^(L-7).
  function automatic int unsigned chunks_per_half(input logic [LW-1:0] layer);
    if (layer <= 5'd7) return 1;
    return 32'd1 << (layer - 5'd7);
  endfunction

  function automatic int unsigned half_offset(input int unsigned layer, input int unsigned h,
                                              input int unsigned k);
    return (h * (32'd1 << (layer - 1)) + k * P) * Q;
  endfunction
endpackage

// File: rtl/ram_b_layer_store.sv
// Beta storage for one layer: flat register with chunk-masked writes and
// side-by-side left/right chunk reads (zero-extended when a half is narrower than a chunk).
module ram_b_layer_store
  import polar_pkg::*;
#(
  parameter int unsigned L = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          half,
  input  logic [2:0]    chunk,
  input  logic [CW-1:0] w_data,
  input  logic [2:0]    r_chunk,
  output logic [CW-1:0] r_left,
  output logic [CW-1:0] r_right
);
  localparam int unsigned H   = 32'd1 << (L - 1);
  localparam int unsigned W   = 2 * H * Q;
  localparam int unsigned C   = chunks_per_half(LW'(L));
  localparam int unsigned CHW = (H < P) ? H * Q : CW;
  localparam int unsigned AW  = $clog2(W);

  logic [W-1:0]  mem_q;
  logic [2:0]    wk, rk;
  logic [AW-1:0] woff, loff, roff;

  always_comb begin
    // Chunk indices wrap within this layer so shared burst counters never overrun it.
    wk   = chunk & 3'(C - 1);
    rk   = r_chunk & 3'(C - 1);
    woff = AW'(half_offset(L, 32'(half), 32'(wk)));
    loff = AW'(half_offset(L, 32'd0, 32'(rk)));
    roff = AW'(half_offset(L, 32'd1, 32'(rk)));
    r_left  = '0;
    r_right = '0;
    r_left[CHW-1:0]  = mem_q[loff +: CHW];
    r_right[CHW-1:0] = mem_q[roff +: CHW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[woff +: CHW] <= w_data[CHW-1:0];
    end
  end
endmodule

// File: rtl/ram_b.sv
// Beta message memory for layers 1..LOG2N: chunked half writes, paired left/right
// chunk reads with registered outputs (a same-cycle read sees pre-write data).
module ram_b
  import polar_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] b_in,
  input  logic [LW-1:0] layer_w,
  input  logic          half_w,
  input  logic          w_valid,
  input  logic          w_first,
  output logic          w_done,
  input  logic          r_start,
  input  logic [LW-1:0] layer_r,
  output logic [CW-1:0] b_out_left,
  output logic [CW-1:0] b_out_right,
  output logic          r_valid,
  output logic          r_last,
  output logic          cmd_err
);
  w_state_e      w_state_q;
  r_state_e      r_state_q;
  logic [LW-1:0] wl_q, rl_q;
  logic          wh_q;
  logic [3:0]    wcnt_q, rcnt_q;
  logic          w_done_q, r_valid_q, r_last_q, cmd_err_q;
  logic [CW-1:0] b_left_q, b_right_q;

  logic          lw_ok, lr_ok, w_start, w_beat, wr_go, wr_half, w_bad, r_bad;
  logic [LW-1:0] wr_layer, rd_layer;
  logic [2:0]    wr_chunk, rd_chunk;
  logic [CW-1:0] sel_left, sel_right;
  logic [CW-1:0] left_a  [1:LOG2N];
  logic [CW-1:0] right_a [1:LOG2N];

  always_comb begin
    lw_ok    = (layer_w >= 5'd1) && (layer_w <= LW'(LOG2N));
    lr_ok    = (layer_r >= 5'd1) && (layer_r <= LW'(LOG2N));
    w_start  = w_valid && w_first;
    w_beat   = (w_state_q == WBurst) && w_valid && !w_first;
    wr_go    = (w_start && lw_ok) || w_beat;
    wr_layer = w_start ? layer_w : wl_q;
    wr_half  = w_start ? half_w : wh_q;
    wr_chunk = w_start ? 3'd0 : wcnt_q[2:0];
    w_bad    = w_start && !lw_ok;
    r_bad    = r_start && !lr_ok && (r_state_q == RIdle);
    rd_layer = (r_state_q == RBurst) ? rl_q : layer_r;
    rd_chunk = (r_state_q == RBurst) ? rcnt_q[2:0] : 3'd0;
    sel_left  = '0;
    sel_right = '0;
    for (int l = 1; l <= LOG2N; l++) begin
      if (rd_layer == LW'(l)) begin
        sel_left  = left_a[l];
        sel_right = right_a[l];
      end
    end
  end

  for (genvar l = 1; l <= LOG2N; l++) begin : g_layer
    ram_b_layer_store #(
      .L(l)
    ) u_store (
      .clk    (clk),
      .rst    (rst),
      .we     (wr_go && (wr_layer == LW'(l))),
      .half   (wr_half),
      .chunk  (wr_chunk),
      .w_data (b_in),
      .r_chunk(rd_chunk),
      .r_left (left_a[l]),
      .r_right(right_a[l])
    );
  end

  // Write FSM; a first beat always restarts, dropping any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      wl_q      <= '0;
      wh_q      <= 1'b0;
      wcnt_q    <= '0;
      w_done_q  <= 1'b0;
    end else begin
      w_done_q <= 1'b0;
      if (w_start && lw_ok) begin
        wl_q   <= layer_w;
        wh_q   <= half_w;
        wcnt_q <= 4'd1;
        if (chunks_per_half(layer_w) == 1) begin
          w_state_q <= WIdle;
          w_done_q  <= 1'b1;
        end else begin
          w_state_q <= WBurst;
        end
      end else if (w_beat) begin
        wcnt_q <= wcnt_q + 4'd1;
        if (wcnt_q == 4'(chunks_per_half(wl_q) - 1)) begin
          w_state_q <= WIdle;
          w_done_q  <= 1'b1;
        end
      end
    end
  end

  // Read FSM; output registers capture the selected chunk at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RIdle;
      rl_q      <= '0;
      rcnt_q    <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      b_left_q  <= '0;
      b_right_q <= '0;
    end else begin
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      b_left_q  <= '0;
      b_right_q <= '0;
      if (r_state_q == RIdle) begin
        if (r_start && lr_ok) begin
          b_left_q  <= sel_left;
          b_right_q <= sel_right;
          r_valid_q <= 1'b1;
          rl_q      <= layer_r;
          rcnt_q    <= 4'd1;
          if (chunks_per_half(layer_r) == 1) r_last_q <= 1'b1;
          else r_state_q <= RBurst;
        end
      end else begin
        b_left_q  <= sel_left;
        b_right_q <= sel_right;
        r_valid_q <= 1'b1;
        rcnt_q    <= rcnt_q + 4'd1;
        if (rcnt_q == 4'(chunks_per_half(rl_q) - 1)) begin
          r_last_q  <= 1'b1;
          r_state_q <= RIdle;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_err_q <= 1'b0;
    else     cmd_err_q <= w_bad || r_bad;
  end

  assign w_done      = w_done_q;
  assign r_valid     = r_valid_q;
  assign r_last      = r_last_q;
  assign cmd_err     = cmd_err_q;
  assign b_out_left  = b_left_q;
  assign b_out_right = b_right_q;
endmodule

// File: tb/tb_ram_b.sv
// Directed self-checking bench for ram_b: writes, bursts, gaps, reset abort,
// command errors and same-cycle read/write ordering.
module tb_ram_b;
  import polar_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] b_in;
  logic [LW-1:0] layer_w, layer_r;
  logic          half_w, w_valid, w_first, r_start;
  logic          w_done, r_valid, r_last, cmd_err;
  logic [CW-1:0] b_out_left, b_out_right;

  int checks = 0;
  int errors = 0;

  ram_b dut (
    .clk        (clk),
    .rst        (rst),
    .b_in       (b_in),
    .layer_w    (layer_w),
    .half_w     (half_w),
    .w_valid    (w_valid),
    .w_first    (w_first),
    .w_done     (w_done),
    .r_start    (r_start),
    .layer_r    (layer_r),
    .b_out_left (b_out_left),
    .b_out_right(b_out_right),
    .r_valid    (r_valid),
    .r_last     (r_last),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // First n messages set to v, rest zero.
  function automatic logic [CW-1:0] msgs(input int unsigned v, input int unsigned n);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < n; i++) c[i*Q +: Q] = Q'(v);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_valid = 0; w_first = 0; r_start = 0;
  endtask

  initial begin
    rst = 1; b_in = '0; layer_w = '0; layer_r = '0; half_w = 0;
    idle_inputs();
    tick(); tick();
    chk("reset_r_valid", {383'b0, r_valid}, '0);
    chk("reset_left", b_out_left, '0);
    chk("reset_right", b_out_right, '0);
    chk("reset_flags", {380'b0, w_done, r_last, cmd_err, r_valid}, '0);
    rst = 0;
    tick();

    // 1: layer 1 left = 5, right = 0x3A, single-beat read.
    w_valid = 1; w_first = 1; layer_w = 1; half_w = 0; b_in = CW'(5);
    tick();
    idle_inputs();
    chk("t1_done_left", {383'b0, w_done}, 1);
    tick();
    chk("t1_done_clear", {383'b0, w_done}, 0);
    w_valid = 1; w_first = 1; layer_w = 1; half_w = 1; b_in = {{(CW-6){1'b1}}, 6'h3A};
    tick();
    idle_inputs();
    chk("t1_done_right", {383'b0, w_done}, 1);
    r_start = 1; layer_r = 1;
    tick();
    r_start = 0;
    chk("t1_left", b_out_left, CW'(5));
    chk("t1_right", b_out_right, CW'(6'h3A));
    chk("t1_valid_last", {382'b0, r_valid, r_last}, 2'b11);
    chk("t1_done_once", {383'b0, w_done}, 0);
    tick();
    chk("t1_valid_drop", {383'b0, r_valid}, 0);

    // 2: layer 10 full bursts, left = k, right = k+8.
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 8; k++) begin
        w_valid = 1; w_first = (k == 0); layer_w = 10; half_w = h[0];
        b_in = msgs(k + 8 * h, P);
        tick();
        if (k < 7) chk("t2_no_done", {383'b0, w_done}, 0);
      end
      idle_inputs();
      chk("t2_done", {383'b0, w_done}, 1);
    end
    r_start = 1; layer_r = 10;
    for (int k = 0; k < 8; k++) begin
      tick();
      r_start = 0;
      chk("t2_left", b_out_left, msgs(k, P));
      chk("t2_right", b_out_right, msgs(k + 8, P));
      chk("t2_valid_last", {382'b0, r_valid, r_last}, {r_valid, (k == 7)});
      chk("t2_valid", {383'b0, r_valid}, 1);
    end
    tick();
    chk("t2_end", {382'b0, r_valid, r_last}, 0);

    // 3: layer 9 left burst with 2-cycle gaps.
    for (int k = 0; k < 4; k++) begin
      w_valid = 1; w_first = (k == 0); layer_w = 9; half_w = 0; b_in = msgs(20 + k, P);
      tick();
      idle_inputs();
      if (k == 3) chk("t3_done", {383'b0, w_done}, 1);
      else chk("t3_no_done", {383'b0, w_done}, 0);
      if (k < 3) begin
        tick();
        chk("t3_gap", {383'b0, w_done}, 0);
        tick();
      end
    end
    tick();
    chk("t3_done_once", {383'b0, w_done}, 0);
    r_start = 1; layer_r = 9;
    for (int k = 0; k < 4; k++) begin
      tick();
      r_start = 0;
      chk("t3_left", b_out_left, msgs(20 + k, P));
      chk("t3_right", b_out_right, '0);
      chk("t3_last", {383'b0, r_last}, {383'b0, (k == 3)});
    end
    tick();

    // 4: reset during beat 3 of a layer 10 read.
    r_start = 1; layer_r = 10;
    for (int k = 0; k < 4; k++) begin
      tick();
      r_start = 0;
    end
    chk("t4_beat3", b_out_left, msgs(3, P));
    #2 rst = 1;
    #1;
    chk("t4_rst_left", b_out_left, '0);
    chk("t4_rst_right", b_out_right, '0);
    chk("t4_rst_flags", {382'b0, r_valid, r_last}, 0);
    tick();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_no_beats", {382'b0, r_valid, r_last}, 0);
    end
    r_start = 1; layer_r = 10;
    for (int k = 0; k < 8; k++) begin
      tick();
      r_start = 0;
      chk("t4_zero", b_out_left | b_out_right, '0);
      chk("t4_valid", {383'b0, r_valid}, 1);
    end
    tick();

    // 5: invalid read and write starts in the same cycle.
    r_start = 1; layer_r = 0;
    w_valid = 1; w_first = 1; layer_w = 11; half_w = 0; b_in = msgs(7, P);
    tick();
    idle_inputs();
    chk("t5_err", {383'b0, cmd_err}, 1);
    chk("t5_no_valid", {383'b0, r_valid}, 0);
    chk("t5_no_done", {383'b0, w_done}, 0);
    tick();
    chk("t5_err_pulse", {383'b0, cmd_err}, 0);
    chk("t5_still_none", {383'b0, r_valid}, 0);
    r_start = 1; layer_r = 1;
    tick();
    r_start = 0;
    chk("t5_storage", b_out_left | b_out_right, '0);

    // 6: same-cycle write and read of layer 4 right.
    w_valid = 1; w_first = 1; layer_w = 4; half_w = 1; b_in = msgs(5, P);
    tick();
    idle_inputs();
    w_valid = 1; w_first = 1; layer_w = 4; half_w = 1; b_in = msgs(6'h1F, P);
    r_start = 1; layer_r = 4;
    tick();
    idle_inputs();
    chk("t6_old_right", b_out_right, msgs(5, 8));
    chk("t6_left", b_out_left, '0);
    chk("t6_last", {382'b0, r_valid, r_last}, 2'b11);
    chk("t6_done", {383'b0, w_done}, 1);
    r_start = 1; layer_r = 4;
    tick();
    r_start = 0;
    chk("t6_new_right", b_out_right, msgs(6'h1F, 8));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
